// File: rtl/id_ex_pipe_if.sv
// ID/EX boundary bundle: decoded ID slot in, registered EX slot and hazard status out.
interface id_ex_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
);
  logic                  ID_valid;
  logic [18:0]           ID_inst;
  logic                  ID_reg_write_signal;
  logic                  ID_mem_read;
  logic                  ID_mem_write;
  logic                  ID_reg2_read_source;
  logic [3:0]            ID_alu_op;
  logic [DATA_WIDTH-1:0] ID_read_data1;
  logic [DATA_WIDTH-1:0] ID_read_data2;
  logic                  flush;
  logic                  hold;

  logic                  EX_valid;
  logic [18:0]           EX_inst;
  logic                  EX_reg_write_signal;
  logic                  EX_mem_read;
  logic                  EX_mem_write;
  logic                  EX_reg2_read_source;
  logic [3:0]            EX_alu_op;
  logic [DATA_WIDTH-1:0] EX_read_data1;
  logic [DATA_WIDTH-1:0] EX_read_data2;
  logic                  stall;
  logic [CNT_WIDTH-1:0]  stall_count;
  logic [CNT_WIDTH-1:0]  flush_count;

  modport master (
    output ID_valid, ID_inst, ID_reg_write_signal, ID_mem_read, ID_mem_write,
           ID_reg2_read_source, ID_alu_op, ID_read_data1, ID_read_data2, flush, hold,
    input  EX_valid, EX_inst, EX_reg_write_signal, EX_mem_read, EX_mem_write,
           EX_reg2_read_source, EX_alu_op, EX_read_data1, EX_read_data2,
           stall, stall_count, flush_count
  );

  modport slave (
    input  ID_valid, ID_inst, ID_reg_write_signal, ID_mem_read, ID_mem_write,
           ID_reg2_read_source, ID_alu_op, ID_read_data1, ID_read_data2, flush, hold,
    output EX_valid, EX_inst, EX_reg_write_signal, EX_mem_read, EX_mem_write,
           EX_reg2_read_source, EX_alu_op, EX_read_data1, EX_read_data2,
           stall, stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall detection, flush/hold handling
// and saturating stall/flush debug counters.
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_pipe_if.slave  bus
);

  typedef struct packed {
    logic                  valid;
    logic [18:0]           inst;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg2_src;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] data1;
    logic [DATA_WIDTH-1:0] data2;
  } ex_slot_t;

  ex_slot_t             ex_q, ex_d, id_slot;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [2:0]           ex_dest, id_src_a, id_src_b;
  logic                 hazard;

  assign ex_dest  = ex_q.inst[13:11];
  assign id_src_a = bus.ID_inst[10:8];
  assign id_src_b = bus.ID_reg2_read_source ? bus.ID_inst[10:8] : bus.ID_inst[7:5];

  // Dest r0 is never written, so a load to it cannot create a dependency.
  assign hazard = ex_q.valid & ex_q.mem_read & (ex_dest != 3'd0) & bus.ID_valid &
                  ((ex_dest == id_src_a) | (ex_dest == id_src_b));

  assign bus.stall = hazard & ~bus.flush & ~rst;

  always_comb begin
    id_slot.valid     = bus.ID_valid;
    id_slot.inst      = bus.ID_inst;
    id_slot.reg_write = bus.ID_reg_write_signal;
    id_slot.mem_read  = bus.ID_mem_read;
    id_slot.mem_write = bus.ID_mem_write;
    id_slot.reg2_src  = bus.ID_reg2_read_source;
    id_slot.alu_op    = bus.ID_alu_op;
    id_slot.data1     = bus.ID_read_data1;
    id_slot.data2     = bus.ID_read_data2;
  end

  always_comb begin
    ex_d        = ex_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.flush) begin
      ex_d = '0;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (bus.hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d = '0;
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end else if (bus.ID_valid) begin
      ex_d = id_slot;
    end else begin
      // An empty ID slot still becomes an all-zero bubble so EX never sees stale fields.
      ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.EX_valid            = ex_q.valid;
  assign bus.EX_inst             = ex_q.inst;
  assign bus.EX_reg_write_signal = ex_q.reg_write;
  assign bus.EX_mem_read         = ex_q.mem_read;
  assign bus.EX_mem_write        = ex_q.mem_write;
  assign bus.EX_reg2_read_source = ex_q.reg2_src;
  assign bus.EX_alu_op           = ex_q.alu_op;
  assign bus.EX_read_data1       = ex_q.data1;
  assign bus.EX_read_data2       = ex_q.data2;
  assign bus.stall_count         = stall_cnt_q;
  assign bus.flush_count         = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg: reset, load-use, srcB select, flush/hold priority, saturation.
module tb_id_ex_pipe_reg;
  localparam int DW = 16;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  id_ex_pipe_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  id_ex_pipe_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [18:0] mk(input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
    return {5'b0, d, a, b, 5'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive the ID slot; remaining control defaults to a plain ALU op.
  task automatic drive(input logic v, input logic [18:0] inst, input logic mr, input logic r2s,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    bus.ID_valid            = v;
    bus.ID_inst             = inst;
    bus.ID_reg_write_signal = 1'b1;
    bus.ID_mem_read         = mr;
    bus.ID_mem_write        = 1'b0;
    bus.ID_reg2_read_source = r2s;
    bus.ID_alu_op           = 4'h3;
    bus.ID_read_data1       = d1;
    bus.ID_read_data2       = d2;
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    rst = 1'b1;
    drive(1'b1, 19'($urandom), 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
    step();
    drive(1'b1, 19'($urandom), 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
    step();
    chk("rst_valid", 32'(bus.EX_valid), 32'd0);
    chk("rst_inst", 32'(bus.EX_inst), 32'd0);
    chk("rst_data1", 32'(bus.EX_read_data1), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_scnt", 32'(bus.stall_count), 32'd0);
    chk("rst_fcnt", 32'(bus.flush_count), 32'd0);

    // First instruction after reset appears one edge later
    rst = 1'b0;
    drive(1'b1, mk(3'd2, 3'd1, 3'd1), 1'b0, 1'b0, 16'hAAAA, 16'h5555);
    step();
    chk("pass_inst", 32'(bus.EX_inst), 32'(mk(3'd2, 3'd1, 3'd1)));
    chk("pass_valid", 32'(bus.EX_valid), 32'd1);
    chk("pass_d1", 32'(bus.EX_read_data1), 32'hAAAA);
    chk("pass_d2", 32'(bus.EX_read_data2), 32'h5555);
    chk("pass_alu", 32'(bus.EX_alu_op), 32'h3);

    // Load-use on srcA
    drive(1'b1, mk(3'd3, 3'd1, 3'd0), 1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    chk("ld_mr", 32'(bus.EX_mem_read), 32'd1);
    drive(1'b1, mk(3'd4, 3'd3, 3'd2), 1'b0, 1'b0, 16'h1234, 16'h4321);
    #1;
    chk("lu_stall", 32'(bus.stall), 32'd1);
    step();
    chk("lu_bub_inst", 32'(bus.EX_inst), 32'd0);
    chk("lu_bub_valid", 32'(bus.EX_valid), 32'd0);
    chk("lu_scnt", 32'(bus.stall_count), 32'd1);
    chk("lu_stall_drop", 32'(bus.stall), 32'd0);
    step();
    chk("lu_consumer", 32'(bus.EX_inst), 32'(mk(3'd4, 3'd3, 3'd2)));
    chk("lu_cons_d1", 32'(bus.EX_read_data1), 32'h1234);

    // No match: load r3, consumer reads r2/r4
    drive(1'b1, mk(3'd3, 3'd1, 3'd0), 1'b1, 1'b0, 16'h0, 16'h0);
    step();
    drive(1'b1, mk(3'd5, 3'd2, 3'd4), 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("nh_stall", 32'(bus.stall), 32'd0);
    step();
    chk("nh_nobubble", 32'(bus.EX_inst), 32'(mk(3'd5, 3'd2, 3'd4)));
    chk("nh_scnt", 32'(bus.stall_count), 32'd1);

    // Load to r0 never stalls
    drive(1'b1, mk(3'd0, 3'd1, 3'd1), 1'b1, 1'b0, 16'h0, 16'h0);
    step();
    drive(1'b1, mk(3'd5, 3'd0, 3'd0), 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("r0_stall", 32'(bus.stall), 32'd0);

    // srcB selection: dest r5, [10:8]=1, [7:5]=5
    drive(1'b1, mk(3'd5, 3'd1, 3'd0), 1'b1, 1'b0, 16'h0, 16'h0);
    step();
    drive(1'b1, mk(3'd6, 3'd1, 3'd5), 1'b0, 1'b0, 16'h0, 16'h0);
    #1;
    chk("srcb_sel0", 32'(bus.stall), 32'd1);
    bus.ID_reg2_read_source = 1'b1;
    #1;
    chk("srcb_sel1", 32'(bus.stall), 32'd0);
    step();
    chk("srcb_pass", 32'(bus.EX_inst), 32'(mk(3'd6, 3'd1, 3'd5)));

    // Flush beats hazard
    drive(1'b1, mk(3'd3, 3'd1, 3'd0), 1'b1, 1'b0, 16'h0, 16'h0);
    step();
    drive(1'b1, mk(3'd4, 3'd3, 3'd2), 1'b0, 1'b0, 16'h0, 16'h0);
    bus.flush = 1'b1;
    #1;
    chk("fl_stall", 32'(bus.stall), 32'd0);
    step();
    bus.flush = 1'b0;
    chk("fl_bub", 32'(bus.EX_inst), 32'd0);
    chk("fl_fcnt", 32'(bus.flush_count), 32'd1);
    chk("fl_scnt", 32'(bus.stall_count), 32'd1);

    // Hold keeps EX frozen while stall stays up
    drive(1'b1, mk(3'd6, 3'd1, 3'd0), 1'b1, 1'b0, 16'h00BE, 16'h0);
    step();
    drive(1'b1, mk(3'd2, 3'd6, 3'd1), 1'b0, 1'b0, 16'h0, 16'h0);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hd_stall", 32'(bus.stall), 32'd1);
      step();
      chk("hd_inst", 32'(bus.EX_inst), 32'(mk(3'd6, 3'd1, 3'd0)));
      chk("hd_d1", 32'(bus.EX_read_data1), 32'h00BE);
      chk("hd_scnt", 32'(bus.stall_count), 32'd1);
    end
    bus.hold = 1'b0;
    #1;
    chk("hd_rel_stall", 32'(bus.stall), 32'd1);
    step();
    chk("hd_rel_bub", 32'(bus.EX_inst), 32'd0);
    chk("hd_rel_scnt", 32'(bus.stall_count), 32'd2);
    step();
    chk("hd_rel_cons", 32'(bus.EX_inst), 32'(mk(3'd2, 3'd6, 3'd1)));

    // Invalid ID slot loads a bubble without counting
    drive(1'b0, mk(3'd7, 3'd7, 3'd7), 1'b0, 1'b0, 16'hFFFF, 16'hFFFF);
    step();
    chk("inv_inst", 32'(bus.EX_inst), 32'd0);
    chk("inv_d1", 32'(bus.EX_read_data1), 32'd0);
    chk("inv_scnt", 32'(bus.stall_count), 32'd2);
    chk("inv_fcnt", 32'(bus.flush_count), 32'd1);

    // Flush counter saturates at 15
    bus.flush = 1'b1;
    for (int i = 0; i < 18; i++) step();
    bus.flush = 1'b0;
    chk("sat_fcnt", 32'(bus.flush_count), 32'd15);
    chk("sat_scnt", 32'(bus.stall_count), 32'd2);

    // Reset clears counters
    rst = 1'b1;
    step();
    chk("rst2_fcnt", 32'(bus.flush_count), 32'd0);
    chk("rst2_scnt", 32'(bus.stall_count), 32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection. It captures the decoded instruction, control signals and register operands from ID, and presents them to EX and to the forwarding unit as EX_inst, EX_reg_write_signal, EX_mem_write and related outputs. On a load-use hazard it raises stall, which freezes PC and IF/ID, and inserts a one-cycle bubble into EX. It also handles branch flush and a global hold, and keeps saturating stall/bubble counters for performance debug.

Parameters:
DATA_WIDTH, 16, width of register operands
CNT_WIDTH, 16, width of the stall and flush counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
ID_valid  in  1  ID slot holds a real instruction
ID_inst  in  19  decoded instruction; dest [13:11], srcA [10:8], srcB [7:5]
ID_reg_write_signal  in  1  instruction writes the register file
ID_mem_read  in  1  instruction is a load
ID_mem_write  in  1  instruction is a store
ID_reg2_read_source  in  1  1: operand B register is [10:8]; 0: operand B register is [7:5]
ID_alu_op  in  4  ALU operation code
ID_read_data1  in  DATA_WIDTH  register file port 1 data
ID_read_data2  in  DATA_WIDTH  register file port 2 data
flush  in  1  branch taken in EX; squash the ID instruction
hold  in  1  global freeze (memory wait)
EX_valid  out  1  registered
EX_inst  out  19  registered
EX_reg_write_signal  out  1  registered
EX_mem_read  out  1  registered
EX_mem_write  out  1  registered
EX_reg2_read_source  out  1  registered
EX_alu_op  out  4  registered
EX_read_data1  out  DATA_WIDTH  registered
EX_read_data2  out  DATA_WIDTH  registered
stall  out  1  combinational; hold PC and IF/ID
stall_count  out  CNT_WIDTH  saturating count of bubbles inserted by load-use
flush_count  out  CNT_WIDTH  saturating count of flushed cycles

Behaviour:
- Reset (rst=1 at clock edge): every registered output is 0, including both counters. Reset overrides all other inputs. stall is 0 while rst=1.
- Definitions:
  - srcB = ID_reg2_read_source ? ID_inst[10:8] : ID_inst[7:5].
  - hazard = EX_valid & EX_mem_read & (EX_inst[13:11] != 0) & ID_valid & ((EX_inst[13:11] == ID_inst[10:8]) | (EX_inst[13:11] == srcB)).
- stall = hazard & ~flush & ~rst. It is purely combinational from the current EX_* outputs and the ID inputs.
- Bubble: EX_valid, EX_inst, every control output and both data outputs load 0. A dest of 0 means the forwarding unit ignores the slot.
- Per-edge priority, highest first:
  1. rst: clear everything.
  2. flush: load bubble; flush_count +1.
  3. hold: keep all EX_* outputs and counters unchanged. stall still reflects current state.
  4. hazard: load bubble; stall_count +1.
  5. Otherwise load all ID_* inputs into EX_*; EX_valid = ID_valid.
- ID_valid=0 with no other event: loads a bubble. Counters do not change.
- A load-use stall lasts exactly one cycle. After the bubble, EX holds no load, so hazard drops. The load is then in MEM and is covered by MEM forwarding.
- A load whose dest is 0 never causes a stall.
- A store in ID whose data register matches the load dest stalls only if that register is srcA or srcB as defined above. No special case for stores.
- Back-to-back loads to the same register followed by a use: one stall per dependent consumer only.
- Counters saturate at all ones and never wrap.
- Latency: ID inputs appear on EX_* one edge after capture. A stall adds exactly one edge.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random ID inputs -> all EX_* = 0, stall = 0, both counters = 0. Release rst -> the next ID instruction appears on EX_* after 1 edge.
- Load-use: EX holds a load with dest r3; ID holds an add with srcA=r3 -> stall=1. Next edge: EX_inst=0, EX_valid=0, stall_count=1. Following edge: the add reaches EX; stall=0.
- No hazard cases: load dest r3 with consumer srcA=r2 and srcB=r4 -> stall=0 and no bubble. Load dest r0 with consumer srcA=r0 -> stall=0.
- srcB selection: load dest r5; ID_inst[7:5]=5 and [10:8]=1. With ID_reg2_read_source=0 -> stall=1. With ID_reg2_read_source=1 -> stall=0.
- Flush vs hazard: hazard and flush asserted together -> stall=0, bubble loaded, flush_count=1, stall_count unchanged.
- Hold: hazard present with hold=1 for 3 cycles -> EX_* unchanged, stall=1 throughout, stall_count unchanged. Release hold -> bubble inserted, stall_count=1.
- Saturation: force 2^CNT_WIDTH+2 flushes (use CNT_WIDTH=4 in this test) -> flush_count stays at 15.
